// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the digit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic {ST_FIRST = 1'b0, ST_MID = 1'b1} sa_state_t;

  // Two's-complement overflow: carry into the MSB disagrees with carry out of it.
  function automatic logic ovf(input logic c_msb, input logic cout);
    return c_msb ^ cout;
  endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// One digit of ripple addition; also exposes the carry into the digit's MSB.
module digit_adder #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout,
  output logic               c_msb
);

  logic [DIGIT_W:0] full_s;

  // Full-width sum; the carry into the MSB is recovered from the MSB's sum bit.
  always_comb begin
    full_s = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    s      = full_s[DIGIT_W-1:0];
    cout   = full_s[DIGIT_W];
    c_msb  = full_s[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b[DIGIT_W-1];
  end

endmodule

// File: rtl/serial_addsub_digit.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first, vld/last framed,
// with registered per-beat sum and per-word carry, overflow and length-error flags.
module serial_addsub_digit
  import serial_arith_pkg::*;
#(
  parameter int DIGIT_W   = 4,
  parameter int MAX_BEATS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               last,
  output logic               out_vld,
  output logic [DIGIT_W-1:0] sum,
  output logic               out_last,
  output logic               carry_out,
  output logic               overflow,
  output logic               err_len
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  sa_state_t          state_q, state_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_vld_q, out_vld_d;
  logic [DIGIT_W-1:0] sum_q, sum_d;
  logic               out_last_q, out_last_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;
  logic               err_len_q, err_len_d;

  logic               mode_s, cin_s, term_s;
  logic [DIGIT_W-1:0] b_eff_s, s_s;
  logic               cout_s, c_msb_s;

  digit_adder #(.DIGIT_W(DIGIT_W)) u_add (
    .a     (a),
    .b     (b_eff_s),
    .cin   (cin_s),
    .s     (s_s),
    .cout  (cout_s),
    .c_msb (c_msb_s)
  );

  // Operand conditioning: the first beat takes mode and carry-in from sub.
  always_comb begin
    case (state_q)
      ST_FIRST: begin
        mode_s = sub;
        cin_s  = sub;
      end
      ST_MID: begin
        mode_s = mode_q;
        cin_s  = carry_q;
      end
      default: begin
        mode_s = 1'b0;
        cin_s  = 1'b0;
      end
    endcase
    b_eff_s = mode_s ? ~b : b;
    term_s  = last | (cnt_q == CNT_W'(MAX_BEATS - 1));
  end

  // Next state; inputs only influence state when vld is high.
  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    out_vld_d   = 1'b0;
    sum_d       = sum_q;
    out_last_d  = 1'b0;
    carry_out_d = 1'b0;
    overflow_d  = 1'b0;
    err_len_d   = 1'b0;
    if (vld) begin
      out_vld_d = 1'b1;
      sum_d     = s_s;
      if (term_s) begin
        out_last_d  = 1'b1;
        carry_out_d = cout_s;
        overflow_d  = ovf(c_msb_s, cout_s);
        err_len_d   = ~last;
        state_d     = ST_FIRST;
        carry_d     = 1'b0;
        cnt_d       = {CNT_W{1'b0}};
      end else begin
        carry_d = cout_s;
        mode_d  = mode_s;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_MID;
      end
    end else begin
      out_vld_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FIRST;
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      out_vld_q   <= 1'b0;
      sum_q       <= {DIGIT_W{1'b0}};
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      out_vld_q   <= out_vld_d;
      sum_q       <= sum_d;
      out_last_q  <= out_last_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      err_len_q   <= err_len_d;
    end
  end

  assign out_vld   = out_vld_q;
  assign sum       = sum_q;
  assign out_last  = out_last_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Directed bench for serial_addsub_digit with DIGIT_W=4, MAX_BEATS=4.
module tb_serial_addsub_digit;

  logic       clk;
  logic       rst;
  logic       vld;
  logic       sub;
  logic [3:0] a;
  logic [3:0] b;
  logic       last;
  logic       out_vld;
  logic [3:0] sum;
  logic       out_last;
  logic       carry_out;
  logic       overflow;
  logic       err_len;

  int checks;
  int errors;

  serial_addsub_digit #(.DIGIT_W(4), .MAX_BEATS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .vld       (vld),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .last      (last),
    .out_vld   (out_vld),
    .sum       (sum),
    .out_last  (out_last),
    .carry_out (carry_out),
    .overflow  (overflow),
    .err_len   (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_vld, input logic [3:0] e_sum,
                         input logic e_last, input logic e_c, input logic e_o, input logic e_e);
    chk({tag, ".out_vld"},   32'(out_vld),   32'(e_vld));
    chk({tag, ".sum"},       32'(sum),       32'(e_sum));
    chk({tag, ".out_last"},  32'(out_last),  32'(e_last));
    chk({tag, ".carry_out"}, 32'(carry_out), 32'(e_c));
    chk({tag, ".overflow"},  32'(overflow),  32'(e_o));
    chk({tag, ".err_len"},   32'(err_len),   32'(e_e));
  endtask

  task automatic beat(input string tag, input logic s_i, input logic [3:0] a_i,
                      input logic [3:0] b_i, input logic l_i, input logic [3:0] e_sum,
                      input logic e_last, input logic e_c, input logic e_o, input logic e_e);
    @(negedge clk);
    vld  = 1'b1;
    sub  = s_i;
    a    = a_i;
    b    = b_i;
    last = l_i;
    @(posedge clk);
    #1;
    chk_all(tag, 1'b1, e_sum, e_last, e_c, e_o, e_e);
  endtask

  task automatic idle(input string tag, input int n, input logic [3:0] held_sum);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vld  = 1'b0;
      sub  = 1'bx;
      a    = 4'bxxxx;
      b    = 4'bxxxx;
      last = 1'bx;
      @(posedge clk);
      #1;
      chk_all(tag, 1'b0, held_sum, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    vld  = 1'b0;
    sub  = 1'b0;
    a    = 4'h0;
    b    = 4'h0;
    last = 1'b0;
    #3;
    chk_all("reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 0x1234 + 0x0FCD = 0x2201
    beat("add1.b1", 1'b0, 4'h4, 4'hD, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("add1.b2", 1'b0, 4'h3, 4'hC, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("add1.b3", 1'b0, 4'h2, 4'hF, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("add1.b4", 1'b0, 4'h1, 4'h0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);

    // 0x03 - 0x05 = 0xFE; sub deasserted on beat 2 must be ignored
    beat("sub.b1", 1'b1, 4'h3, 4'h5, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("sub.b2", 1'b0, 4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);

    // 0x7F + 0x01 overflows; then 0xFF + 0x01 carries, back to back
    beat("ovf.b1", 1'b0, 4'hF, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("ovf.b2", 1'b0, 4'h7, 4'h0, 1'b1, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0);
    beat("cy.b1",  1'b0, 4'hF, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("cy.b2",  1'b0, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);

    // first word again with bubbles
    beat("bub.b1", 1'b0, 4'h4, 4'hD, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("bub.g1", 1, 4'h1);
    beat("bub.b2", 1'b0, 4'h3, 4'hC, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("bub.g2", 3, 4'h0);
    beat("bub.b3", 1'b0, 4'h2, 4'hF, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("bub.g3", 2, 4'h2);
    beat("bub.b4", 1'b0, 4'h1, 4'h0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);

    // no last: forced termination after 4 beats; 5th beat opens a fresh sub word
    beat("len.b1", 1'b0, 4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("len.b2", 1'b0, 4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("len.b3", 1'b0, 4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("len.b4", 1'b0, 4'h1, 4'h1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1);
    beat("len.b5", 1'b1, 4'h1, 4'h1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);

    // async reset mid-word, after a beat that leaves carry and sub mode pending
    beat("rst.b1", 1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("rst.b2", 1'b0, 4'h1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vld = 1'b0;
    #2;
    chk("rst.pre.out_vld", 32'(out_vld), 32'(1'b1));
    rst = 1'b1;
    #1;
    chk_all("rst.async", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle("rst.idle", 1, 4'h0);
    beat("post.b1", 1'b0, 4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("post.b2", 1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("post.idle", 1, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
